// File: rtl/bnn_neuron_array_if.sv
// Stream interface for bnn_neuron_array: activation/weight beats in, per-neuron results out.
// The master side drives beats and out_ready; the slave side is the neuron tile.
interface bnn_neuron_array_if #(
    parameter int unsigned PARALLEL_INPUTS  = 32,
    parameter int unsigned PARALLEL_NEURONS = 1,
    parameter int unsigned ACC_WIDTH        = 10
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [PARALLEL_INPUTS-1:0]              in_data;
    logic [PARALLEL_INPUTS-1:0]              in_mask;
    logic [PARALLEL_NEURONS*PARALLEL_INPUTS-1:0] in_weights;
    logic [PARALLEL_NEURONS*ACC_WIDTH-1:0]   in_thresh;
    logic                                    in_last;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [PARALLEL_NEURONS-1:0]             out_bits;
    logic [PARALLEL_NEURONS*ACC_WIDTH-1:0]   out_count;
    logic                                    err_len;
    logic [ACC_WIDTH-1:0]                    cfg_fan_in;

    modport master (
        output in_valid, in_data, in_mask, in_weights, in_thresh, in_last, out_ready, cfg_fan_in,
        input  in_ready, out_valid, out_bits, out_count, err_len
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_weights, in_thresh, in_last, out_ready, cfg_fan_in,
        output in_ready, out_valid, out_bits, out_count, err_len
    );
endinterface

// File: rtl/bnn_neuron_array.sv
// bnn_neuron_array: XNOR-popcount binary neuron tile emitting threshold bits or raw counts.
// Optional fan-in length check is enabled by defining BNN_NEURON_LEN_CHECK_EN.
module bnn_neuron_array #(
    parameter int unsigned PARALLEL_INPUTS  = 32,
    parameter int unsigned PARALLEL_NEURONS = 1,
    parameter int unsigned MAX_FAN_IN       = 784,
    parameter int unsigned OUTPUT_LAYER     = 0
) (
    input logic clk,
    input logic rst,
    bnn_neuron_array_if.slave bus
);
    localparam int unsigned ACC_WIDTH = $clog2(MAX_FAN_IN + 1);
    localparam int unsigned PI = PARALLEL_INPUTS;
    localparam int unsigned PN = PARALLEL_NEURONS;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                    state;
    logic                      rdy_en;
    logic                      out_valid_q;
    logic [PN-1:0]             bits_q;
    logic [PN*ACC_WIDTH-1:0]   count_q;
    logic [ACC_WIDTH-1:0]      acc   [PN];
    logic [ACC_WIDTH-1:0]      pop   [PN];
    logic [ACC_WIDTH-1:0]      total [PN];
    logic [PI-1:0]             match [PN];
    logic                      in_ready;
    logic                      accept;
    logic                      last_acc;

    // rdy_en keeps in_ready low until the first clock edge after reset release
    assign in_ready      = rdy_en && !(out_valid_q && !bus.out_ready);
    assign accept        = bus.in_valid && in_ready;
    assign last_acc      = accept && bus.in_last;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bits  = bits_q;
    assign bus.out_count = count_q;

    always_comb begin
        for (int unsigned n = 0; n < PN; n++) begin
            match[n] = ~(bus.in_data ^ bus.in_weights[n*PI +: PI]) & bus.in_mask;
            pop[n]   = '0;
            for (int unsigned i = 0; i < PI; i++) begin
                pop[n] = pop[n] + ACC_WIDTH'(match[n][i]);
            end
            total[n] = acc[n] + pop[n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACCUM;
            rdy_en      <= 1'b0;
            out_valid_q <= 1'b0;
            bits_q      <= '0;
            count_q     <= '0;
            for (int unsigned n = 0; n < PN; n++) begin
                acc[n] <= '0;
            end
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                for (int unsigned n = 0; n < PN; n++) begin
                    acc[n] <= bus.in_last ? '0 : total[n];
                end
            end
            // A last beat in HOLD implies out_ready, so the new result replaces the old one
            if (last_acc) begin
                for (int unsigned n = 0; n < PN; n++) begin
                    count_q[n*ACC_WIDTH +: ACC_WIDTH] <= total[n];
                    bits_q[n] <= (OUTPUT_LAYER != 0) ? 1'b0
                                 : (total[n] >= bus.in_thresh[n*ACC_WIDTH +: ACC_WIDTH]);
                end
                state       <= HOLD;
                out_valid_q <= 1'b1;
            end else if (state == HOLD && bus.out_ready) begin
                state       <= ACCUM;
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef BNN_NEURON_LEN_CHECK_EN
    logic [ACC_WIDTH-1:0] len_cnt;
    logic [ACC_WIDTH-1:0] mask_pop;
    logic [ACC_WIDTH-1:0] len_sum;
    logic                 err_q;

    always_comb begin
        mask_pop = '0;
        for (int unsigned i = 0; i < PI; i++) begin
            mask_pop = mask_pop + ACC_WIDTH'(bus.in_mask[i]);
        end
        len_sum = len_cnt + mask_pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_cnt <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            len_cnt <= bus.in_last ? '0 : len_sum;
            if (bus.in_last && (len_sum != bus.cfg_fan_in)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err_len = err_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^bus.cfg_fan_in;
    assign bus.err_len = 1'b0;
`endif
endmodule
